// File: rtl/av2_forward_transform_4x4.sv
// 4x4 forward DCT-II (DCT_DCT): streams 16 raster residuals in, runs a row pass
// then a column pass, and streams 16 saturated raster coefficients out.
module av2_forward_transform_4x4 #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int COS_BIT   = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_residual,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_coeff,
    output logic                        out_last,
    output logic                        busy
);

    localparam int ACC_W = 24;
    localparam logic signed [31:0] C32     = 32'sd2896;
    localparam logic signed [31:0] C16     = 32'sd3784;
    localparam logic signed [31:0] C48     = 32'sd1567;
    localparam logic signed [31:0] RND     = 32'sd1 <<< (COS_BIT - 1);
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_WIDTH - 1));

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

    state_t state, state_nx;
    logic [3:0] cnt, ocnt;
    logic [1:0] idx;

    logic signed [ACC_W-1:0]     blk  [16];
    logic signed [OUT_WIDTH-1:0] coef [16];
    logic signed [31:0]          a    [4];
    logic signed [31:0]          y    [4];
    logic signed [31:0]          s0, s1, s2, s3;

    function automatic logic signed [31:0] rs(input logic signed [31:0] x);
        return (x + RND) >>> COS_BIT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [31:0] x);
        if (x > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if (x < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return x[OUT_WIDTH-1:0];
    endfunction

    // One shared fdct4 datapath: row idx in ROW, column idx in COL.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (state == COL) a[k] = 32'(blk[{2'(k), idx}]);
            else              a[k] = 32'(blk[{idx, 2'(k)}]);
        end
        s0 = a[0] + a[3];
        s1 = a[1] + a[2];
        s2 = a[1] - a[2];
        s3 = a[0] - a[3];
        y[0] = rs(C32 * (s0 + s1));
        y[1] = rs(C48 * s2 + C16 * s3);
        y[2] = rs(C32 * (s0 - s1));
        y[3] = rs(C48 * s3 - C16 * s2);
    end

    always_ff @(posedge clk) begin
        case (state)
            LOAD: if (in_valid) blk[cnt] <= ACC_W'(in_residual);
            ROW:  for (int unsigned k = 0; k < 4; k++) blk[{idx, 2'(k)}] <= y[k][ACC_W-1:0];
            COL:  for (int unsigned k = 0; k < 4; k++) coef[{2'(k), idx}] <= sat(y[k]);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
            idx   <= '0;
            ocnt  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD:     if (in_valid) cnt <= cnt + 4'd1;
                ROW, COL: idx <= idx + 2'd1;
                OUT:      if (out_ready) ocnt <= ocnt + 4'd1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_coeff = '0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && cnt == 4'd15) state_nx = ROW;
            end
            ROW: if (idx == 2'd3) state_nx = COL;
            COL: if (idx == 2'd3) state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                out_coeff = coef[ocnt];
                out_last  = (ocnt == 4'd15);
                if (out_ready && ocnt == 4'd15) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

endmodule

// File: tb/tb_av2_forward_transform_4x4.sv
// Scoreboard bench for av2_forward_transform_4x4: a reference fdct pushes
// expected coefficients when a block is loaded; the drain pops and compares.
module tb_av2_forward_transform_4x4;

    localparam int IW = 16;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [IW-1:0] in_residual = '0;
    logic in_ready, out_valid, out_last, busy;
    logic signed [OW-1:0] out_coeff;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int blk_in[16];
    int got[16];

    av2_forward_transform_4x4 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COS_BIT(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_residual(in_residual), .out_valid(out_valid), .out_ready(out_ready),
        .out_coeff(out_coeff), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rsm(input int x);
        return (x + 2048) >>> 12;
    endfunction

    function automatic void fd(input int a0, input int a1, input int a2, input int a3,
                               output int y0, output int y1, output int y2, output int y3);
        y0 = rsm(2896 * ((a0 + a3) + (a1 + a2)));
        y1 = rsm(1567 * (a1 - a2) + 3784 * (a0 - a3));
        y2 = rsm(2896 * ((a0 + a3) - (a1 + a2)));
        y3 = rsm(1567 * (a0 - a3) - 3784 * (a1 - a2));
    endfunction

    function automatic void model_push();
        int t[16];
        int r[16];
        for (int i = 0; i < 4; i++)
            fd(blk_in[i*4], blk_in[i*4+1], blk_in[i*4+2], blk_in[i*4+3],
               t[i*4], t[i*4+1], t[i*4+2], t[i*4+3]);
        for (int c = 0; c < 4; c++)
            fd(t[c], t[4+c], t[8+c], t[12+c], r[c], r[4+c], r[8+c], r[12+c]);
        for (int i = 0; i < 16; i++) begin
            if (r[i] > 32767) r[i] = 32767;
            if (r[i] < -32768) r[i] = -32768;
            exp_q.push_back(r[i]);
        end
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_block(input int n, input int gap_pct);
        if (n == 16) model_push();
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                checks++;
                if (busy !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL load_bubble: busy=%b in_ready=%b required busy=0 in_ready=1", busy, in_ready);
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_residual = IW'(blk_in[i]);
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_beat%0d: busy=%b in_ready=%b required busy=0 in_ready=1", i, busy, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int nbeats);
        int lat = 0;
        int cyc = 0;
        int n = 0;
        bit stalled = 0;
        logic signed [OW-1:0] prev_c;
        logic prev_l;
        logic signed [OW-1:0] e;
        int ev;
        bit rdy;
        in_valid = 1'b1;
        in_residual = 16'sh5a5;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 8", lat);
            if (out_valid !== 1'b1) return;
        end
        while (n < nbeats && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            out_ready = rdy;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL out_ctrl: out_valid=%b in_ready=%b busy=%b required 1,0,1",
                         out_valid, in_ready, busy);
            end
            if (stalled) begin
                checks++;
                if (out_coeff !== prev_c || out_last !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: coeff=%0d last=%b required %0d %b",
                             out_coeff, out_last, prev_c, prev_l);
                end
            end
            if (rdy) begin
                ev = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
                e = OW'(ev);
                got[n] = int'(out_coeff);
                checks++;
                if (out_coeff !== e || ev == 99999) begin
                    errors++;
                    $display("FAIL coeff%0d: got %0d required %0d", n, out_coeff, ev);
                end
                checks++;
                if (out_last !== (n == 15)) begin
                    errors++;
                    $display("FAIL last%0d: got %b required %b", n, out_last, (n == 15));
                end
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev_c = out_coeff;
                prev_l = out_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (n != nbeats) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats required %0d", n, nbeats);
        end
        if (nbeats == 16) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_last: out_valid=%b in_ready=%b busy=%b required 0,1,0",
                         out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_last !== 1'b0 || out_coeff !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b last=%b coeff=%0d required 1,0,0,0,0",
                     in_ready, out_valid, busy, out_last, out_coeff);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 16; i++) blk_in[i] = 1;
        send_block(16, 0);
        drain(0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] != ((i == 0) ? 8 : 0)) begin
                errors++;
                $display("FAIL ones_c%0d: got %0d required %0d", i, got[i], (i == 0) ? 8 : 0);
            end
        end
    endtask

    task automatic test_dc100();
        for (int i = 0; i < 16; i++) blk_in[i] = 100;
        send_block(16, 0);
        drain(0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] != ((i == 0) ? 800 : 0)) begin
                errors++;
                $display("FAIL dc100_c%0d: got %0d required %0d", i, got[i], (i == 0) ? 800 : 0);
            end
        end
    endtask

    task automatic check_impulse(input string tag);
        int idx[5] = '{0, 1, 4, 8, 12};
        int val[5] = '{32, 42, 42, 32, 17};
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[idx[k]] != val[k]) begin
                errors++;
                $display("FAIL %s_c%0d: got %0d required %0d", tag, idx[k], got[idx[k]], val[k]);
            end
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 16; i++) blk_in[i] = (i == 0) ? 64 : 0;
        send_block(16, 0);
        drain(0, 16);
        check_impulse("impulse");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) blk_in[i] = (i == 0) ? 64 : 0;
        send_block(16, 0);
        drain(1, 16);
        check_impulse("bp_impulse");
    endtask

    task automatic test_gaps();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) begin
                case (b)
                    0:       blk_in[i] = 1023;
                    1:       blk_in[i] = (((i >> 2) + i) % 2 == 0) ? 1023 : -1023;
                    default: blk_in[i] = int'($urandom_range(0, 2046)) - 1023;
                endcase
            end
            send_block(16, 35);
            drain(b % 2, 16);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) blk_in[i] = int'($urandom_range(0, 2046)) - 1023;
            send_block(16, 0);
            drain(0, 16);
        end
    endtask

    task automatic test_reset_mid(input int in_out);
        if (in_out == 0) begin
            for (int i = 0; i < 16; i++) blk_in[i] = 7;
            send_block(9, 0);
        end else begin
            for (int i = 0; i < 16; i++) blk_in[i] = (i == 0) ? 64 : 0;
            send_block(16, 0);
            drain(0, 5);
        end
        do_reset();
        exp_q.delete();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset%0d_state: in_ready=%b out_valid=%b busy=%b last=%b required 1,0,0,0",
                     in_out, in_ready, out_valid, busy, out_last);
        end
        for (int i = 0; i < 16; i++) blk_in[i] = 1;
        send_block(16, 0);
        drain(0, 16);
        checks++;
        if (got[0] != 8) begin
            errors++;
            $display("FAIL midreset%0d_recover: got %0d required 8", in_out, got[0]);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_dc100();
        test_impulse();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_reset_mid(0);
        test_reset_mid(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
